// File: rtl/mem_access_unit.sv
// Load/store unit between EX/MEM and a req/gnt/rvalid data bus.
// Stalls the pipeline per access; faults on illegal or misaligned requests and on bus timeout.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_request_in,
    input  logic        mem_request_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [4:0]  rd_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        load_valid_out,
    output logic [31:0] load_data_out,
    output logic [4:0]  rd_out,
    output logic        fault_valid_out,
    output logic [1:0]  fault_cause_out
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitR, StDone} state_e;

    state_e      state_q;
    logic [31:0] addr_q, wdata_q, load_data_q;
    logic [1:0]  off_q, fault_cause_q;
    logic [3:0]  be_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q, rd_out_q;
    logic        we_q, load_valid_q, fault_valid_q;
    logic [7:0]  wd_q;

    logic        legal, misaligned, accept;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    always_comb begin
        legal = 1'b0;
        unique case (funct3_in)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~mem_request_write_in;
            default:                legal = 1'b0;
        endcase
        misaligned = ((funct3_in[1:0] == 2'b01) && addr_in[0]) ||
                     ((funct3_in[1:0] == 2'b10) && (addr_in[1:0] != 2'b00));
        accept = (state_q == StIdle) && mem_request_in && legal && !misaligned;

        // Sub-word stores are replicated across lanes; the byte enables pick the live lane.
        be_d    = 4'b1111;
        wdata_d = wdata_in;
        case (funct3_in[1:0])
            2'b00: begin
                be_d    = 4'b0001 << addr_in[1:0];
                wdata_d = {4{wdata_in[7:0]}};
            end
            2'b01: begin
                be_d    = addr_in[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{wdata_in[15:0]}};
            end
            default: ;
        endcase
    end

    function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] off,
                                            input logic [2:0] f3);
        logic [31:0] sh;
        sh = d >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return d;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            wdata_q       <= '0;
            load_data_q   <= '0;
            off_q         <= '0;
            fault_cause_q <= '0;
            be_q          <= '0;
            funct3_q      <= '0;
            rd_q          <= '0;
            rd_out_q      <= '0;
            we_q          <= 1'b0;
            load_valid_q  <= 1'b0;
            fault_valid_q <= 1'b0;
            wd_q          <= '0;
        end else begin
            load_valid_q  <= 1'b0;
            fault_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (mem_request_in) begin
                        if (!legal || misaligned) begin
                            fault_valid_q <= 1'b1;
                            fault_cause_q <= !legal ? 2'b10 : 2'b01;
                        end else begin
                            addr_q   <= {addr_in[31:2], 2'b00};
                            off_q    <= addr_in[1:0];
                            wdata_q  <= wdata_d;
                            be_q     <= be_d;
                            funct3_q <= funct3_in;
                            rd_q     <= rd_in;
                            we_q     <= mem_request_write_in;
                            wd_q     <= '0;
                            state_q  <= StReq;
                        end
                    end
                end
                StReq, StWaitR: begin
                    wd_q <= wd_q + 8'd1;
                    if (state_q == StReq && dmem_gnt && we_q) begin
                        state_q <= StDone;
                    end else if (dmem_rvalid && (state_q == StWaitR || dmem_gnt)) begin
                        load_data_q  <= extract(dmem_rdata, off_q, funct3_q);
                        rd_out_q     <= rd_q;
                        load_valid_q <= 1'b1;
                        state_q      <= StDone;
                    end else if (wd_q == 8'd254) begin
                        // 255th cycle spent waiting on the bus: give up.
                        fault_valid_q <= 1'b1;
                        fault_cause_q <= 2'b11;
                        state_q       <= StDone;
                    end else if (state_q == StReq && dmem_gnt) begin
                        state_q <= StWaitR;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dmem_req        = (state_q == StReq);
    assign dmem_we         = we_q & dmem_req;
    assign dmem_addr       = addr_q;
    assign dmem_wdata      = wdata_q;
    assign dmem_be         = be_q;
    assign stall_out       = (state_q == StReq) || (state_q == StWaitR) || accept;
    assign load_valid_out  = load_valid_q;
    assign load_data_out   = load_data_q;
    assign rd_out          = rd_out_q;
    assign fault_valid_out = fault_valid_q;
    assign fault_cause_out = fault_cause_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; load results and faults are checked against queued
// expectations when the unit reports them.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_request_in, mem_request_write_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in, wdata_in;
    logic [4:0]  rd_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_out, load_valid_out, fault_valid_out;
    logic [31:0] load_data_out;
    logic [4:0]  rd_out;
    logic [1:0]  fault_cause_out;

    int tests = 0;
    int fails = 0;
    logic [36:0] load_q[$];
    logic [1:0]  fault_q[$];

    mem_access_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .mem_request_in       (mem_request_in),
        .mem_request_write_in (mem_request_write_in),
        .funct3_in            (funct3_in),
        .addr_in              (addr_in),
        .wdata_in             (wdata_in),
        .rd_in                (rd_in),
        .dmem_req             (dmem_req),
        .dmem_we              (dmem_we),
        .dmem_addr            (dmem_addr),
        .dmem_wdata           (dmem_wdata),
        .dmem_be              (dmem_be),
        .dmem_gnt             (dmem_gnt),
        .dmem_rvalid          (dmem_rvalid),
        .dmem_rdata           (dmem_rdata),
        .stall_out            (stall_out),
        .load_valid_out       (load_valid_out),
        .load_data_out        (load_data_out),
        .rd_out               (rd_out),
        .fault_valid_out      (fault_valid_out),
        .fault_cause_out      (fault_cause_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then retire any reported load or fault against the queues.
    task automatic tick();
        @(posedge clk);
        #1;
        if (load_valid_out === 1'b1) begin
            if (load_q.size() == 0) check("unexpected_load", {36'h0, load_valid_out}, 37'h0);
            else check("load_result", {load_data_out, rd_out}, load_q.pop_front());
        end
        if (fault_valid_out === 1'b1) begin
            if (fault_q.size() == 0) check("unexpected_fault", {36'h0, fault_valid_out}, 37'h0);
            else check("fault_cause", {35'h0, fault_cause_out}, {35'h0, fault_q.pop_front()});
        end
    endtask

    task automatic xfer(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [4:0] rd,
                        input int gnt_wait, input int rv_wait, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_data,
                        input int exp_stall);
        int stalls = 0;
        mem_request_in = 1'b1; mem_request_write_in = we; funct3_in = f3;
        addr_in = addr; wdata_in = wdata; rd_in = rd;
        #1;
        stalls += int'(stall_out);
        if (!we) load_q.push_back({exp_data, rd});
        tick();
        mem_request_in = 1'b0;
        for (int i = 0; i <= gnt_wait; i++) begin
            check({tag, "_req"}, {36'h0, dmem_req}, 37'h1);
            check({tag, "_we"}, {36'h0, dmem_we}, {36'h0, we});
            check({tag, "_addr"}, {5'h0, dmem_addr}, {5'h0, addr[31:2], 2'b00});
            check({tag, "_be"}, {33'h0, dmem_be}, {33'h0, exp_be});
            if (we) check({tag, "_wdata"}, {5'h0, dmem_wdata}, {5'h0, exp_wdata});
            stalls += int'(stall_out);
            if (i == gnt_wait) begin
                dmem_gnt = 1'b1;
                if (!we && rv_wait == 0) begin dmem_rvalid = 1'b1; dmem_rdata = rdata; end
            end
            tick();
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        end
        if (!we) begin
            for (int i = 1; i <= rv_wait; i++) begin
                check({tag, "_wait_noreq"}, {36'h0, dmem_req}, 37'h0);
                stalls += int'(stall_out);
                if (i == rv_wait) begin dmem_rvalid = 1'b1; dmem_rdata = rdata; end
                tick();
                dmem_rvalid = 1'b0;
            end
        end
        check({tag, "_done_stall"}, {36'h0, stall_out}, 37'h0);
        check({tag, "_done_lvalid"}, {36'h0, load_valid_out}, {36'h0, !we});
        tick();
        check({tag, "_idle_lvalid"}, {36'h0, load_valid_out}, 37'h0);
        check({tag, "_stall_cycles"}, 37'(stalls), 37'(exp_stall));
    endtask

    task automatic bad_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [1:0] cause);
        mem_request_in = 1'b1; mem_request_write_in = we; funct3_in = f3; addr_in = addr;
        #1;
        check({tag, "_nostall"}, {36'h0, stall_out}, 37'h0);
        fault_q.push_back(cause);
        tick();
        mem_request_in = 1'b0;
        check({tag, "_noreq"}, {36'h0, dmem_req}, 37'h0);
        check({tag, "_fvalid"}, {36'h0, fault_valid_out}, 37'h1);
        tick();
        check({tag, "_fpulse"}, {36'h0, fault_valid_out}, 37'h0);
    endtask

    initial begin
        int n;
        rst = 1'b0; mem_request_in = 1'b0; mem_request_write_in = 1'b0; funct3_in = '0;
        addr_in = '0; wdata_in = '0; rd_in = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        dmem_rdata = '0;
        #3;
        check("reset_req", {36'h0, dmem_req}, 37'h0);
        check("reset_be", {33'h0, dmem_be}, 37'h0);
        check("reset_outs", {load_data_out, rd_out}, 37'h0);
        check("reset_stall", {35'h0, stall_out, fault_valid_out}, 37'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        xfer("lw", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 5'd5, 0, 1, 4'b1111, 32'h0,
             32'hDEADBEEF, 3);
        check("lw_hold", {5'h0, load_data_out}, {5'h0, 32'hDEADBEEF});
        xfer("lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 5'd6, 0, 0, 4'b1000, 32'h0,
             32'hFFFFFF80, 2);
        xfer("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 5'd7, 1, 2, 4'b1000, 32'h0,
             32'h00000080, 5);
        xfer("sh", 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 5'd0, 3, 0, 4'b1100,
             32'hABCDABCD, 32'h0, 5);
        xfer("sw", 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 5'd0, 0, 0, 4'b1111,
             32'hCAFEF00D, 32'h0, 2);
        xfer("sb", 1'b1, 3'b000, 32'h41, 32'h000000A5, 32'h0, 5'd0, 0, 0, 4'b0010,
             32'hA5A5A5A5, 32'h0, 2);
        xfer("lh", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 5'd9, 0, 1, 4'b1100, 32'h0,
             32'hFFFF8001, 3);
        xfer("lhu", 1'b0, 3'b101, 32'h100, 32'h0, 32'h12348765, 5'd10, 0, 0, 4'b0011, 32'h0,
             32'h00008765, 2);

        bad_req("lw_mis", 1'b0, 3'b010, 32'h101, 2'b01);
        bad_req("lh_mis", 1'b0, 3'b001, 32'h103, 2'b01);
        bad_req("f3_011", 1'b0, 3'b011, 32'h100, 2'b10);
        bad_req("st_f3_100", 1'b1, 3'b100, 32'h100, 2'b10);
        bad_req("ill_over_mis", 1'b0, 3'b111, 32'h101, 2'b10);

        // Bus grants but never returns data.
        mem_request_in = 1'b1; mem_request_write_in = 1'b0; funct3_in = 3'b010;
        addr_in = 32'h300; rd_in = 5'd11;
        fault_q.push_back(2'b11);
        tick();
        mem_request_in = 1'b0; dmem_gnt = 1'b1;
        n = 1;
        tick(); n++;
        dmem_gnt = 1'b0;
        while (fault_valid_out !== 1'b1 && n < 400) begin tick(); n++; end
        check("wd_cycles", 37'(n), 37'd256);
        check("wd_stall", {35'h0, stall_out, dmem_req}, 37'h0);
        check("wd_lvalid", {36'h0, load_valid_out}, 37'h0);
        check("wd_data_hold", {load_data_out, rd_out}, {32'h00008765, 5'd10});
        tick();
        check("wd_idle_stall", {36'h0, stall_out}, 37'h0);

        // Reset in the middle of a load.
        mem_request_in = 1'b1; addr_in = 32'h400; rd_in = 5'd12;
        tick();
        mem_request_in = 1'b0; dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        check("rst_pre_stall", {36'h0, stall_out}, 37'h1);
        rst = 1'b0;
        #1;
        check("rst_req", {36'h0, dmem_req}, 37'h0);
        check("rst_stall", {36'h0, stall_out}, 37'h0);
        check("rst_outs", {load_data_out, rd_out}, 37'h0);
        check("rst_be_addr", {1'b0, dmem_be, dmem_addr}, 37'h0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h55555555;
        tick();
        rst = 1'b1;
        tick();
        tick();
        dmem_rvalid = 1'b0;
        check("rst_rv_ignored", {load_data_out, load_valid_out, stall_out, 3'b000}, 37'h0);
        check("queues_empty", 37'(load_q.size() + fault_q.size()), 37'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
